// File: rtl/vend_pkg.sv
// Shared types for the vending dispense path: drink codes, queued order record, FSM state encoding.
package vend_pkg;

  localparam logic [1:0] DRINK_NONE = 2'd0;
  localparam logic [1:0] DRINK_A    = 2'd1;
  localparam logic [1:0] DRINK_B    = 2'd2;

  typedef struct packed {
    logic [1:0] drink;
    logic       change;
  } order_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_MOTOR     = 2'd1;
  localparam state_t ST_WAIT_DROP = 2'd2;
  localparam state_t ST_CHANGE    = 2'd3;

endpackage

// File: rtl/vend_order_fifo.sv
// Pending-order queue. A push while full is still taken when a pop frees the head slot that cycle.
module vend_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: queues sale-FSM orders, runs motor, drop check and change ejector.
// Define VEND_DISPENSE_STATS_EN to add saturating stat_a / stat_b / stat_coin counters.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_TIMEOUT = 64
`ifdef VEND_DISPENSE_STATS_EN
  ,
  parameter int STAT_W       = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        drinks_in,
  input  logic              change_in,
  input  logic              drop_sense,
  input  logic              coin_ack,
  input  logic              fault_clr,
  output logic              motor_a,
  output logic              motor_b,
  output logic              coin_eject,
  output logic              busy,
  output logic              overflow,
  output logic              fault
`ifdef VEND_DISPENSE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_a,
  output logic [STAT_W-1:0] stat_b,
  output logic [STAT_W-1:0] stat_coin
`endif
);

  localparam int MCW = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
  localparam int DCW = (DROP_TIMEOUT > 1) ? $clog2(DROP_TIMEOUT) : 1;
  localparam logic [MCW-1:0] MOTOR_LAST = MCW'(MOTOR_CYCLES - 1);
  localparam logic [DCW-1:0] DROP_LAST  = DCW'(DROP_TIMEOUT - 1);

  state_t         state;
  state_t         state_nxt;
  order_t         cur;
  order_t         new_order;
  logic [MCW-1:0] motor_cnt;
  logic [DCW-1:0] drop_cnt;
  logic [2:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic           order_valid;
  logic           order_lost;
  logic           drop_timeout;

  assign order_valid  = (drinks_in == DRINK_A) || (drinks_in == DRINK_B);
  assign new_order    = '{drink: drinks_in, change: change_in};
  assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
  assign order_lost   = order_valid && fifo_full && !fifo_pop;
  assign drop_timeout = (state == ST_WAIT_DROP) && !drop_sense && (drop_cnt == DROP_LAST);

  vend_order_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (order_valid),
    .pop   (fifo_pop),
    .din   (new_order),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!fifo_empty) state_nxt = ST_MOTOR;
      ST_MOTOR:     if (motor_cnt == MOTOR_LAST) state_nxt = ST_WAIT_DROP;
      ST_WAIT_DROP: if (drop_sense || drop_timeout) state_nxt = cur.change ? ST_CHANGE : ST_IDLE;
      ST_CHANGE:    if (coin_ack) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Counters restart whenever their state is left, so they never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur       <= '0;
      motor_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (fifo_pop) cur <= fifo_dout;
      motor_cnt <= (state == ST_MOTOR && state_nxt == ST_MOTOR) ? motor_cnt + 1'b1 : '0;
      drop_cnt  <= (state == ST_WAIT_DROP && state_nxt == ST_WAIT_DROP) ? drop_cnt + 1'b1 : '0;
    end
  end

  // Outputs are a registered decode of the current state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      motor_a    <= 1'b0;
      motor_b    <= 1'b0;
      coin_eject <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      fault      <= 1'b0;
    end else begin
      motor_a    <= (state == ST_MOTOR) && (cur.drink == DRINK_A);
      motor_b    <= (state == ST_MOTOR) && (cur.drink == DRINK_B);
      coin_eject <= (state == ST_CHANGE);
      busy       <= (state != ST_IDLE) || !fifo_empty;
      if (order_lost)     overflow <= 1'b1;
      else if (fault_clr) overflow <= 1'b0;
      if (drop_timeout)   fault <= 1'b1;
      else if (fault_clr) fault <= 1'b0;
    end
  end

`ifdef VEND_DISPENSE_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_a    <= '0;
      stat_b    <= '0;
      stat_coin <= '0;
    end else begin
      if (state == ST_WAIT_DROP && drop_sense) begin
        if (cur.drink == DRINK_A && stat_a != STAT_MAX) stat_a <= stat_a + 1'b1;
        if (cur.drink == DRINK_B && stat_b != STAT_MAX) stat_b <= stat_b + 1'b1;
      end
      if (state == ST_CHANGE && coin_ack && stat_coin != STAT_MAX) stat_coin <= stat_coin + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: per-cycle vector table plus directed multi-cycle sequences.
module tb_vend_dispense_ctrl;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] drinks_in;
  logic       change_in;
  logic       drop_sense;
  logic       coin_ack;
  logic       fault_clr;
  logic       motor_a;
  logic       motor_b;
  logic       coin_eject;
  logic       busy;
  logic       overflow;
  logic       fault;
`ifdef VEND_DISPENSE_STATS_EN
  logic [15:0] stat_a;
  logic [15:0] stat_b;
  logic [15:0] stat_coin;
`endif

  always #5 clk = ~clk;

  vend_dispense_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .drinks_in  (drinks_in),
    .change_in  (change_in),
    .drop_sense (drop_sense),
    .coin_ack   (coin_ack),
    .fault_clr  (fault_clr),
    .motor_a    (motor_a),
    .motor_b    (motor_b),
    .coin_eject (coin_eject),
    .busy       (busy),
    .overflow   (overflow),
    .fault      (fault)
`ifdef VEND_DISPENSE_STATS_EN
    ,
    .stat_a     (stat_a),
    .stat_b     (stat_b),
    .stat_coin  (stat_coin)
`endif
  );

  // One row per clock: inputs sampled at that edge, outputs expected just after it.
  typedef struct {
    int         scen;
    int         idx;
    logic [1:0] drinks;
    logic       chg;
    logic       drop;
    logic       ack;
    logic [5:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  int   errors = 0;
  int   checks = 0;
  int   pulses_a, pulses_b, pulses_ce, high_a;
  logic prev_a, prev_b, prev_ce;

  function automatic logic [5:0] outs();
    return {motor_a, motor_b, coin_eject, busy, overflow, fault};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] d, input logic c, input logic ds,
                               input logic ack, input logic clr, input logic r);
    drinks_in  = d;
    change_in  = c;
    drop_sense = ds;
    coin_ack   = ack;
    fault_clr  = clr;
    rst        = r;
  endtask

  task automatic clearCounts();
    pulses_a  = 0;
    pulses_b  = 0;
    pulses_ce = 0;
    high_a    = 0;
    prev_a    = motor_a;
    prev_b    = motor_b;
    prev_ce   = coin_eject;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (motor_a) high_a++;
    if (motor_a && !prev_a) pulses_a++;
    if (motor_b && !prev_b) pulses_b++;
    if (coin_eject && !prev_ce) pulses_ce++;
    prev_a  = motor_a;
    prev_b  = motor_b;
    prev_ce = coin_eject;
  endtask

  task automatic addVec(input int scen, input int idx, input logic [1:0] d, input logic c,
                        input logic ds, input logic ack, input logic [5:0] e);
    vec_t v;
    v.scen    = scen;
    v.idx     = idx;
    v.drinks  = d;
    v.chg     = c;
    v.drop    = ds;
    v.ack     = ack;
    v.exp_out = e;
    vecs.push_back(v);
  endtask

  // Expected word is {motor_a, motor_b, coin_eject, busy, overflow, fault}.
  task automatic buildTable();
    for (int i = 0; i < 15; i++) begin
      logic [5:0] e;
      if (i >= 2 && i <= 9)       e = 6'b100100;
      else if (i >= 1 && i <= 12) e = 6'b000100;
      else                        e = 6'b000000;
      addVec(1, i, (i == 0) ? 2'd1 : 2'd0, 1'b0, (i == 12), 1'b0, e);
    end
    for (int i = 0; i < 17; i++) begin
      logic [5:0] e;
      if (i >= 2 && i <= 9)       e = 6'b010100;
      else if (i >= 11 && i <= 14) e = 6'b001100;
      else if (i >= 1 && i <= 10) e = 6'b000100;
      else                        e = 6'b000000;
      addVec(2, i, (i == 0) ? 2'd2 : 2'd0, (i == 0), (i == 10), (i == 14), e);
    end
  endtask

  // Runs until busy drops, answering coin_eject with a single coin_ack pulse.
  task automatic runToIdle(input logic auto_drop, input int budget, input string name);
    bit   done;
    logic acked;
    logic ack_now;
    done  = 1'b0;
    acked = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      ack_now = coin_eject && !acked;
      acked   = coin_eject && (acked || ack_now);
      applyStimulus(2'd0, 1'b0, auto_drop, ack_now, 1'b0, 1'b0);
      step();
      if (!busy && c >= 2) done = 1'b1;
    end
    checkOutput({name, "_returns_idle"}, done, 1);
  endtask

  initial begin
    int act;

    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkOutput("reset_outputs", outs(), 6'b000000);

    buildTable();
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].drinks, vecs[k].chg, vecs[k].drop, vecs[k].ack, 1'b0, 1'b0);
      step();
      checkOutput($sformatf("s%0d_cycle%0d", vecs[k].scen, vecs[k].idx), outs(), vecs[k].exp_out);
    end

    // Six back-to-back A orders: the sixth finds the queue full and is lost.
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    clearCounts();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    checkOutput("s3_ovf_before_6th", overflow, 0);
    applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("s3_ovf_after_6th", overflow, 1);
    runToIdle(1'b1, 400, "s3");
    checkOutput("s3_a_pulses", pulses_a, 5);
    checkOutput("s3_a_high_cycles", high_a, 40);
    checkOutput("s3_b_pulses", pulses_b, 0);
    checkOutput("s3_ovf_sticky", overflow, 1);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("s3_ovf_cleared", overflow, 0);

    clearCounts();
    applyStimulus(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    runToIdle(1'b1, 100, "s6");
    checkOutput("s6_b_pulses", pulses_b, 1);
    checkOutput("s6_a_pulses", pulses_a, 0);
    checkOutput("s6_coin_pulses", pulses_ce, 1);
`ifdef VEND_DISPENSE_STATS_EN
    checkOutput("s6_stat_a", stat_a, 5);
    checkOutput("s6_stat_b", stat_b, 1);
    checkOutput("s6_stat_coin", stat_coin, 1);
`endif

    // Fill the queue, then push exactly on the edge the FSM pops: the push must be kept.
    clearCounts();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int k = 5; k < 11; k++) begin
      applyStimulus(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    applyStimulus(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("s7_full_push_with_pop", overflow, 0);
    runToIdle(1'b1, 400, "s7");
    checkOutput("s7_a_pulses", pulses_a, 5);
    checkOutput("s7_b_pulses", pulses_b, 1);

    // Drop never seen: fault after 64 WAIT_DROP samples, with a same-cycle clear that must lose.
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    clearCounts();
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int c = 1; c <= 72; c++) begin
      applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    checkOutput("s4_fault_before_timeout", fault, 0);
    checkOutput("s4_motor_high_cycles", high_a, 8);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("s4_fault_set_beats_clr", fault, 1);
    checkOutput("s4_coin_not_yet", coin_eject, 0);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("s4_coin_after_timeout", coin_eject, 1);
    runToIdle(1'b0, 50, "s4");
    checkOutput("s4_coin_pulses", pulses_ce, 1);
    checkOutput("s4_fault_sticky", fault, 1);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("s4_fault_cleared", fault, 0);

    // Reset in the middle of a vend with two orders still queued.
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int k = 3; k < 6; k++) begin
      applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    checkOutput("s5_motor_running", motor_a, 1);
    applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("s5_reset_outputs", outs(), 6'b000000);
    act = 0;
    for (int k = 0; k < 30; k++) begin
      applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      if (motor_a || motor_b || coin_eject || busy) act++;
    end
    checkOutput("s5_no_activity_after_reset", act, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
